// File: rtl/rv32i_pkg.sv
// RV32I shared definitions: opcodes, ALU/branch codes and the ID/EX payload.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_op_e;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu_a;
        logic [XLEN-1:0] alu_b;
        alu_op_e         alu_op;
        logic [2:0]      branch;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            is_branch;
        logic            is_jal;
        logic            is_jalr;
        logic            illegal;
        logic [2:0]      funct3;
    } id_ex_t;

    // funct3/funct7[5] to ALU op; SUB exists only for register-register ops.
    function automatic alu_op_e alu_decode(input logic [2:0] funct3,
                                           input logic       f7b5,
                                           input logic       is_reg);
        alu_op_e op;
        op = ALU_ADD;
        case (funct3)
            3'b000:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; format chosen from the opcode.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] imm_c
);

    always_comb begin
        imm_c = '0;
        case (instr[6:0])
            OP_IMM, LOAD, JALR: imm_c = {{20{instr[31]}}, instr[31:20]};
            STORE:              imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            BRANCH:             imm_c = {{19{instr[31]}}, instr[31], instr[7],
                                         instr[30:25], instr[11:8], 1'b0};
            LUI, AUIPC:         imm_c = {instr[31:12], 12'b0};
            JAL:                imm_c = {{11{instr[31]}}, instr[31], instr[19:12],
                                         instr[20], instr[30:21], 1'b0};
            default:            imm_c = '0;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode-to-execute stage: decode, immediate, forwarding, operand select,
// load-use bubble insertion and the ID/EX pipeline register.
module id_ex_stage
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic            stall,
    input  logic            flush,
    input  logic            mem_fwd_en,
    input  logic            wb_fwd_en,
    input  logic [4:0]      mem_rd,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic            load_use_hazard,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_alu_a,
    output logic [XLEN-1:0] ex_alu_b,
    output logic [3:0]      ex_alu_op,
    output logic [2:0]      ex_branch,
    output logic [XLEN-1:0] ex_rs1,
    output logic [XLEN-1:0] ex_rs2,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_is_branch,
    output logic            ex_is_jal,
    output logic            ex_is_jalr,
    output logic            ex_illegal,
    output logic [2:0]      ex_funct3
);

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic            uses_rs2;
    id_ex_t          dec;
    id_ex_t          ex_d;
    id_ex_t          ex_q;

    assign opcode = id_instr[6:0];
    assign rd     = id_instr[11:7];
    assign funct3 = id_instr[14:12];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];

    imm_gen u_imm_gen (
        .instr (id_instr),
        .imm_c (imm)
    );

    // Youngest producer wins; x0 is hardwired to zero regardless of bypass.
    function automatic logic [XLEN-1:0] fwd(input logic [4:0]      rs,
                                            input logic [XLEN-1:0] rf_data);
        logic [XLEN-1:0] v;
        v = rf_data;
        if (rs == 5'd0)
            v = '0;
        else if (mem_fwd_en && (mem_rd == rs))
            v = mem_fwd_data;
        else if (wb_fwd_en && (wb_rd == rs))
            v = wb_fwd_data;
        return v;
    endfunction

    assign rs1_fwd  = fwd(rs1, id_rs1_data);
    assign rs2_fwd  = fwd(rs2, id_rs2_data);
    assign uses_rs2 = (opcode == OP) || (opcode == STORE) || (opcode == BRANCH);

    assign load_use_hazard = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                             ((ex_q.rd == rs1) || (uses_rs2 && (ex_q.rd == rs2)));

    // Full decode of the ID instruction into an EX payload.
    always_comb begin
        dec           = '0;
        dec.valid     = 1'b1;
        dec.pc        = id_pc;
        dec.rs1       = rs1_fwd;
        dec.rs2       = rs2_fwd;
        dec.imm       = imm;
        dec.rd        = rd;
        dec.funct3    = funct3;
        dec.branch    = funct3;
        dec.alu_op    = ALU_ADD;
        dec.alu_a     = rs1_fwd;
        dec.alu_b     = rs2_fwd;
        case (opcode)
            OP: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = alu_decode(funct3, id_instr[30], 1'b1);
            end
            OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = alu_decode(funct3, id_instr[30], 1'b0);
                dec.alu_b     = imm;
            end
            LOAD: begin
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.alu_b     = imm;
            end
            STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_b     = imm;
            end
            BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011)
                    dec.illegal   = 1'b1;
                else
                    dec.is_branch = 1'b1;
            end
            LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_a     = '0;
                dec.alu_b     = imm;
            end
            AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_a     = id_pc;
                dec.alu_b     = imm;
            end
            JAL: begin
                dec.reg_write = 1'b1;
                dec.is_jal    = 1'b1;
                dec.alu_a     = id_pc;
                dec.alu_b     = XLEN'(4);
            end
            JALR: begin
                dec.reg_write = 1'b1;
                dec.is_jalr   = 1'b1;
                dec.alu_a     = id_pc;
                dec.alu_b     = XLEN'(4);
            end
            default: dec.illegal = 1'b1;
        endcase
        if (rd == 5'd0)
            dec.reg_write = 1'b0;
    end

    // Bubble: kill validity and all control, keep datapath fields stable.
    function automatic id_ex_t bubble(input id_ex_t e);
        id_ex_t b;
        b           = e;
        b.valid     = 1'b0;
        b.reg_write = 1'b0;
        b.mem_read  = 1'b0;
        b.mem_write = 1'b0;
        b.is_branch = 1'b0;
        b.is_jal    = 1'b0;
        b.is_jalr   = 1'b0;
        b.illegal   = 1'b0;
        return b;
    endfunction

    // Update priority: flush > stall > load-use bubble > normal capture.
    always_comb begin
        ex_d = ex_q;
        if (flush)
            ex_d = bubble(ex_q);
        else if (stall)
            ex_d = ex_q;
        else if (load_use_hazard || !id_valid)
            ex_d = bubble(ex_q);
        else
            ex_d = dec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    assign ex_valid     = ex_q.valid;
    assign ex_pc        = ex_q.pc;
    assign ex_alu_a     = ex_q.alu_a;
    assign ex_alu_b     = ex_q.alu_b;
    assign ex_alu_op    = 4'(ex_q.alu_op);
    assign ex_branch    = ex_q.branch;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_imm       = ex_q.imm;
    assign ex_rd        = ex_q.rd;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_mem_write = ex_q.mem_write;
    assign ex_is_branch = ex_q.is_branch;
    assign ex_is_jal    = ex_q.is_jal;
    assign ex_is_jalr   = ex_q.is_jalr;
    assign ex_illegal   = ex_q.illegal;
    assign ex_funct3    = ex_q.funct3;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic        stall;
    logic        flush;
    logic        mem_fwd_en;
    logic        wb_fwd_en;
    logic [4:0]  mem_rd;
    logic [4:0]  wb_rd;
    logic [31:0] mem_fwd_data;
    logic [31:0] wb_fwd_data;
    logic        load_use_hazard;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_alu_a;
    logic [31:0] ex_alu_b;
    logic [3:0]  ex_alu_op;
    logic [2:0]  ex_branch;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic        ex_illegal;
    logic [2:0]  ex_funct3;

    int n_tests;
    int n_fail;

    id_ex_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_rs1_data     (id_rs1_data),
        .id_rs2_data     (id_rs2_data),
        .stall           (stall),
        .flush           (flush),
        .mem_fwd_en      (mem_fwd_en),
        .wb_fwd_en       (wb_fwd_en),
        .mem_rd          (mem_rd),
        .wb_rd           (wb_rd),
        .mem_fwd_data    (mem_fwd_data),
        .wb_fwd_data     (wb_fwd_data),
        .load_use_hazard (load_use_hazard),
        .ex_valid        (ex_valid),
        .ex_pc           (ex_pc),
        .ex_alu_a        (ex_alu_a),
        .ex_alu_b        (ex_alu_b),
        .ex_alu_op       (ex_alu_op),
        .ex_branch       (ex_branch),
        .ex_rs1          (ex_rs1),
        .ex_rs2          (ex_rs2),
        .ex_imm          (ex_imm),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_is_branch    (ex_is_branch),
        .ex_is_jal       (ex_is_jal),
        .ex_is_jalr      (ex_is_jalr),
        .ex_illegal      (ex_illegal),
        .ex_funct3       (ex_funct3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
        id_valid    = 1'b1;
        id_instr    = instr;
        id_pc       = pc;
        id_rs1_data = a;
        id_rs2_data = b;
    endtask

    task automatic no_fwd();
        mem_fwd_en = 1'b0;
        wb_fwd_en  = 1'b0;
        mem_rd     = 5'd0;
        wb_rd      = 5'd0;
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b1;
        id_valid     = 1'b0;
        id_instr     = 32'h0;
        id_pc        = 32'h0;
        id_rs1_data  = 32'h0;
        id_rs2_data  = 32'h0;
        stall        = 1'b0;
        flush        = 1'b0;
        mem_fwd_data = 32'h0;
        wb_fwd_data  = 32'h0;
        no_fwd();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_valid",  32'(ex_valid),     32'd0);
        check("rst_alu_op", 32'(ex_alu_op),    32'd0);
        check("rst_branch", 32'(ex_branch),    32'd0);
        check("rst_pc",     ex_pc,             32'd0);
        check("rst_alu_a",  ex_alu_a,          32'd0);
        check("rst_rw",     32'(ex_reg_write), 32'd0);
        rst_n = 1'b1;

        // ADDI x1,x0,5 : x0 source reads zero even with nonzero RF data
        drive(32'h00500093, 32'h100, 32'h1234, 32'h5678);
        tick();
        check("addi_valid", 32'(ex_valid),     32'd1);
        check("addi_a",     ex_alu_a,          32'd0);
        check("addi_b",     ex_alu_b,          32'd5);
        check("addi_op",    32'(ex_alu_op),    32'd0);
        check("addi_rd",    32'(ex_rd),        32'd1);
        check("addi_rw",    32'(ex_reg_write), 32'd1);
        check("addi_pc",    ex_pc,             32'h100);

        // SUB x3,x1,x2 : MEM beats WB on x1, x2 from RF
        drive(32'h402081B3, 32'h104, 32'hAAAA, 32'd7);
        mem_fwd_en = 1'b1; mem_rd = 5'd1; mem_fwd_data = 32'd10;
        wb_fwd_en  = 1'b1; wb_rd  = 5'd1; wb_fwd_data  = 32'd99;
        tick();
        check("sub_mem_prio_a", ex_alu_a,       32'd10);
        check("sub_rf_b",       ex_alu_b,       32'd7);
        check("sub_op",         32'(ex_alu_op), 32'h8);
        check("sub_rd",         32'(ex_rd),     32'd3);

        // SUB again : x1 from MEM, x2 from WB
        drive(32'h402081B3, 32'h108, 32'hAAAA, 32'hBBBB);
        wb_rd = 5'd2; wb_fwd_data = 32'd3;
        tick();
        check("sub_a",   ex_alu_a,       32'd10);
        check("sub_wb_b", ex_alu_b,      32'd3);
        check("sub_rs2", ex_rs2,         32'd3);
        check("sub_op2", 32'(ex_alu_op), 32'h8);
        no_fwd();

        // LW x5,0(x1)
        drive(32'h0000A283, 32'h10C, 32'h200, 32'h0);
        tick();
        check("lw_mr", 32'(ex_mem_read),  32'd1);
        check("lw_a",  ex_alu_a,          32'h200);
        check("lw_b",  ex_alu_b,          32'd0);
        check("lw_f3", 32'(ex_funct3),    32'd2);
        check("lw_rw", 32'(ex_reg_write), 32'd1);

        // ADD x6,x5,x1 : load-use on x5
        drive(32'h00128333, 32'h110, 32'hDEAD, 32'h200);
        #1;
        check("lu_hazard", 32'(load_use_hazard), 32'd1);
        tick();
        check("lu_bubble_valid", 32'(ex_valid),        32'd0);
        check("lu_bubble_rw",    32'(ex_reg_write),    32'd0);
        check("lu_bubble_mr",    32'(ex_mem_read),     32'd0);
        check("lu_hazard_clr",   32'(load_use_hazard), 32'd0);
        mem_fwd_en = 1'b1; mem_rd = 5'd5; mem_fwd_data = 32'h55;
        tick();
        check("add_valid", 32'(ex_valid),  32'd1);
        check("add_a",     ex_alu_a,       32'h55);
        check("add_b",     ex_alu_b,       32'h200);
        check("add_op",    32'(ex_alu_op), 32'd0);
        check("add_rd",    32'(ex_rd),     32'd6);
        check("add_pc",    ex_pc,          32'h110);
        no_fwd();

        // x0 never forwarded even if MEM claims rd=0
        drive(32'h000003B3, 32'h114, 32'h1111, 32'h2222);
        mem_fwd_en = 1'b1; mem_rd = 5'd0; mem_fwd_data = 32'hDEAD;
        tick();
        check("x0_a", ex_alu_a, 32'd0);
        check("x0_b", ex_alu_b, 32'd0);
        no_fwd();

        // BEQ x1,x2,+8
        drive(32'h00208463, 32'h118, 32'h7, 32'h9);
        tick();
        check("beq_br",   32'(ex_is_branch), 32'd1);
        check("beq_cond", 32'(ex_branch),    32'd0);
        check("beq_imm",  ex_imm,            32'd8);
        check("beq_rw",   32'(ex_reg_write), 32'd0);
        check("beq_b",    ex_alu_b,          32'h9);

        // Stall 3 cycles with a different instruction waiting in ID
        stall = 1'b1;
        drive(32'h00500093, 32'h200, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 32'(ex_valid),     32'd1);
            check("stall_br",    32'(ex_is_branch), 32'd1);
            check("stall_imm",   ex_imm,            32'd8);
            check("stall_pc",    ex_pc,             32'h118);
        end
        flush = 1'b1;
        tick();
        check("flush_valid", 32'(ex_valid),     32'd0);
        check("flush_br",    32'(ex_is_branch), 32'd0);
        stall = 1'b0;
        flush = 1'b0;

        // id_valid=0 captures a bubble
        id_valid = 1'b0;
        tick();
        check("idle_valid", 32'(ex_valid),     32'd0);
        check("idle_rw",    32'(ex_reg_write), 32'd0);

        // Illegal word
        drive(32'hFFFFFFFF, 32'h300, 32'h0, 32'h0);
        tick();
        check("ill_flag",  32'(ex_illegal),   32'd1);
        check("ill_valid", 32'(ex_valid),     32'd1);
        check("ill_rw",    32'(ex_reg_write), 32'd0);
        check("ill_mw",    32'(ex_mem_write), 32'd0);
        check("ill_br",    32'(ex_is_branch), 32'd0);

        // JAL x1,+16 : link operands pc and 4
        drive(32'h010000EF, 32'h400, 32'h0, 32'h0);
        tick();
        check("jal_flag", 32'(ex_is_jal),    32'd1);
        check("jal_a",    ex_alu_a,          32'h400);
        check("jal_b",    ex_alu_b,          32'd4);
        check("jal_imm",  ex_imm,            32'd16);
        check("jal_ill",  32'(ex_illegal),   32'd0);

        // LUI x2,0x12345
        drive(32'h12345137, 32'h404, 32'hFFFF, 32'h0);
        tick();
        check("lui_a",  ex_alu_a,          32'd0);
        check("lui_b",  ex_alu_b,          32'h12345000);
        check("lui_rw", 32'(ex_reg_write), 32'd1);
        check("lui_rd", 32'(ex_rd),        32'd2);

        // Async reset mid-stall, between clock edges
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(ex_valid),     32'd0);
        check("arst_b",     ex_alu_b,          32'd0);
        check("arst_rw",    32'(ex_reg_write), 32'd0);
        check("arst_rd",    32'(ex_rd),        32'd0);
        check("arst_pc",    ex_pc,             32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("arst_hold_valid", 32'(ex_valid), 32'd0);
        check("arst_hold_b",     ex_alu_b,      32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute stage of the RV32I pipeline, sitting directly upstream of the ALU. It takes a fetched instruction plus register-file read data and does four things:
- decodes the ALU operation code and branch condition;
- generates the immediate;
- resolves operand forwarding from MEM/WB and selects the ALU A/B operands;
- registers everything into the ID/EX pipeline register.

It also detects load-use hazards and inserts the bubble itself. Stall and flush handling live here too.

## Interface
- XLEN, 32: datapath width (only 32 supported).
- clk  in  1  pipeline clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- id_valid  in  1  ID slot holds a real instruction.
- id_instr  in  32  instruction word.
- id_pc  in  32  instruction PC.
- id_rs1_data, id_rs2_data  in  32 each  register-file read data.
- stall  in  1  downstream busy; hold the EX register.
- flush  in  1  branch/jump taken; kill the instruction entering EX.
- mem_fwd_en, wb_fwd_en  in  1 each  MEM/WB stage will write a register.
- mem_rd, wb_rd  in  5 each  destination registers.
- mem_fwd_data, wb_fwd_data  in  32 each  forwarded values.
- load_use_hazard  out  1  combinational; upstream must hold ID this cycle.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc  out  32  registered PC.
- ex_alu_a, ex_alu_b  out  32 each  ALU operands.
- ex_alu_op  out  4  ALU opcode.
- ex_branch  out  3  branch condition, equal to funct3.
- ex_rs1, ex_rs2  out  32 each  forwarded rs1 (JALR base) and rs2 (store data).
- ex_imm  out  32  sign-extended immediate.
- ex_rd  out  5  destination register.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_is_jal, ex_is_jalr, ex_illegal  out  1 each  control bits.
- ex_funct3  out  3  memory access size/sign.

## Operation
- ALU op: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1001.
  - SUB only for R-type with funct7[5]=1; SRA/SRAI when funct7[5]=1.
  - Loads, stores, LUI, AUIPC, JAL and JALR use ADD.
- Immediates: I, S, B, U and J formats per the RV32I spec, sign-extended from instr[31].
- Operand A:
  - rs1 (forwarded) for R-type, OP-IMM, load, store, branch.
  - PC for AUIPC, JAL, JALR.
  - 0 for LUI.
- Operand B:
  - rs2 (forwarded) for R-type and branch.
  - immediate for OP-IMM, load, store, LUI, AUIPC.
  - constant 4 for JAL/JALR (link value).
- Forwarding, per source register, in priority order:
  1. MEM if mem_fwd_en and mem_rd==rs and rs!=0.
  2. Else WB under the same rule.
  3. Else register-file data.
  - rs==0 always yields 0.
- Control bits per opcode:
  - reg_write for R, OP-IMM, load, LUI, AUIPC, JAL, JALR, with rd==0 forcing reg_write=0.
  - mem_read for loads; mem_write for stores.
  - is_branch for BRANCH, with funct3 010/011 flagged illegal.
- Illegal or unknown opcode: ex_illegal=1, ex_valid=1, all other control bits 0.
- load_use_hazard = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==rs1 or, for formats that read rs2, ex_rd==rs2).

## Timing
- Register update priority each rising clk: flush > stall > load_use_hazard > normal.
  - flush: bubble, i.e. ex_valid=0 and all control bits 0; datapath outputs don't-care but deterministic (hold).
  - stall (no flush): every ex_* output holds.
  - hazard: bubble loaded into EX; the ID instruction re-presents next cycle, when forwarding from MEM resolves it.
  - normal: decoded ID instruction captured; id_valid=0 captures a bubble.
- Latency: one cycle from ID inputs to ex_* outputs.
- load_use_hazard is combinational and ignores stall/flush; upstream qualifies it.
- Reset: all ex_* outputs 0, including ex_alu_op=0000 and ex_branch=000; ex_valid=0. A reset asserted mid-stall discards the held instruction.

## Structure
- Shared package rv32i_pkg holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR);
  - ALU op codes (ALU_ADD..ALU_SRA);
  - branch codes (BR_EQ..BR_GEU).
  The ALU uses the same package.
- One sub-module: imm_gen (combinational immediate generator). Decode, forwarding and the register stay in this module.

## Test plan
- ADDI x1,x0,5 (0x00500093): next cycle ex_alu_a=0, ex_alu_b=5, ex_alu_op=0000, ex_rd=1, ex_reg_write=1.
- SUB x3,x1,x2 (0x402081B3) with mem_rd=1/data 10 and wb_rd=1/data 99 (MEM must win) plus wb_rd=2/data 3: ex_alu_a=10, ex_alu_b=3, ex_alu_op=1000.
- LW x5,0(x1) (0x0000A283) then ADD x6,x5,x1 (0x00128333):
  - load_use_hazard=1 for one cycle; next ex_valid=0.
  - ADD enters EX the following cycle.
- BEQ x1,x2,+8 (0x00208463): ex_is_branch=1, ex_branch=000, ex_imm=8, ex_reg_write=0.
- stall held 3 cycles: ex_* outputs unchanged. flush asserted together with stall: ex_valid=0 next cycle.
- Illegal word 0xFFFFFFFF: ex_illegal=1, ex_reg_write=0. Async rst_n low mid-cycle: all outputs 0 immediately.
